// File: rtl/matrix_convolution.sv
// 3x3 valid convolution of a 6x6 byte tile into a 4x4 array of 16-bit sums.
// Nine taps per output pixel are split over two cycles on five external DSP lanes.
module matrix_convolution (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [0:5][0:5][7:0]    input_tile,
  input  logic [0:2][0:2][7:0]    kernel,
  output logic [0:3][0:3][15:0]   c,
  output logic [0:4][17:0]        dsp_a0,
  output logic [0:4][17:0]        dsp_b0,
  input  logic [0:4][36:0]        dsp_out,
  output logic                    dsp_ce,
  output logic                    done
);

  // Handshake: start is a one-cycle request honoured only in IDLE with no job
  // pending; done is a one-cycle pulse and start seen during COMPUTE/DONE is dropped.
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    go_q, go_d;
  logic [3:0]              p_q, p_d;
  logic                    phase_q, phase_d;
  logic [15:0]             partial_q, partial_d;
  logic [0:5][0:5][7:0]    tile_q, tile_d;
  logic [0:2][0:2][7:0]    kern_q, kern_d;
  logic [0:3][0:3][15:0]   c_q, c_d;
  logic [15:0]             lane_sum;

  // Lane l carries tap l in phase 0 and tap l+5 in phase 1; tap 9 does not exist.
  always_comb begin
    dsp_a0 = '0;
    dsp_b0 = '0;
    for (int l = 0; l < 5; l++) begin
      logic [3:0] tap;
      logic [1:0] ki, kj;
      logic [2:0] r_idx, c_idx;
      tap   = phase_q ? 4'(l + 5) : 4'(l);
      ki    = 2'(tap / 4'd3);
      kj    = 2'(tap % 4'd3);
      r_idx = {1'b0, p_q[3:2]} + {1'b0, ki};
      c_idx = {1'b0, p_q[1:0]} + {1'b0, kj};
      if (state_q == COMPUTE && tap < 4'd9) begin
        dsp_a0[l] = {10'd0, tile_q[r_idx][c_idx]};
        dsp_b0[l] = {10'd0, kern_q[ki][kj]};
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < 5; l++) begin
      if (!(phase_q && l == 4)) lane_sum = lane_sum + dsp_out[l][15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    go_d      = go_q;
    p_d       = p_q;
    phase_d   = phase_q;
    partial_d = partial_q;
    tile_d    = tile_q;
    kern_d    = kern_q;
    c_d       = c_q;
    unique case (state_q)
      IDLE: begin
        // Acceptance cycle captures the operands; COMPUTE begins one edge later.
        if (go_q) begin
          go_d    = 1'b0;
          state_d = COMPUTE;
          p_d     = '0;
          phase_d = 1'b0;
        end else if (start) begin
          go_d   = 1'b1;
          tile_d = input_tile;
          kern_d = kernel;
        end
      end
      COMPUTE: begin
        if (!phase_q) begin
          partial_d = lane_sum;
          phase_d   = 1'b1;
        end else begin
          c_d[p_q[3:2]][p_q[1:0]] = partial_q + lane_sum;
          phase_d = 1'b0;
          p_d     = p_q + 4'd1;
          if (p_q == 4'd15) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      p_q       <= '0;
      phase_q   <= 1'b0;
      partial_q <= '0;
      tile_q    <= '0;
      kern_q    <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      p_q       <= p_d;
      phase_q   <= phase_d;
      partial_q <= partial_d;
      tile_q    <= tile_d;
      kern_q    <= kern_d;
      c_q       <= c_d;
    end
  end

  assign c      = c_q;
  assign dsp_ce = (state_q == COMPUTE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_matrix_convolution.sv
// Bench for matrix_convolution: behavioural DSP lanes, vector table, scoreboard
// of expected outputs, and hand-written abort / mid-job disturbance sequences.
module tb_matrix_convolution;

  typedef logic [0:5][0:5][7:0] tile_t;
  typedef logic [0:2][0:2][7:0] kern_t;
  typedef struct {
    tile_t       tile;
    kern_t       kern;
    logic [15:0] c00;
    logic [15:0] c33;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  tile_t                 input_tile;
  kern_t                 kernel;
  logic [0:3][0:3][15:0] c;
  logic [0:4][17:0]      dsp_a0, dsp_b0;
  logic [0:4][36:0]      dsp_out;
  logic                  dsp_ce, done;

  logic [15:0] exp_q[$];
  logic [15:0] last_c33;
  bit          has_prev;
  int          errors, checks;
  vec_t        vecs[5];

  matrix_convolution dut (
    .clk(clk), .rst_n(rst_n), .start(start), .input_tile(input_tile), .kernel(kernel),
    .c(c), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_out(dsp_out), .dsp_ce(dsp_ce), .done(done)
  );

  always #5 clk = ~clk;

  // Lanes return the true product with junk in the ignored upper bits.
  function automatic logic [36:0] mul(input logic [17:0] a, input logic [17:0] b);
    logic [35:0] pr;
    pr = a * b;
    return {21'h15A5A5, pr[15:0]};
  endfunction

  for (genvar l = 0; l < 5; l++) begin : g_dsp
    assign dsp_out[l] = mul(dsp_a0[l], dsp_b0[l]);
  end

  function automatic logic [15:0] conv(input tile_t t, input kern_t k, input int i, input int j);
    logic [15:0] s;
    s = '0;
    for (int ki = 0; ki < 3; ki++)
      for (int kj = 0; kj < 3; kj++)
        s = s + 16'(t[i+ki][j+kj]) * 16'(k[ki][kj]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input tile_t t, input kern_t k, input bit disturb,
                         input logic [15:0] c00_exp, input logic [15:0] c33_exp);
    int done_cnt, done_at, ce_cnt, ce_bad, lane_bad, p, ph, i, j, tap;
    logic [17:0] ea, eb;
    logic [15:0] got;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) exp_q.push_back(conv(t, k, r, q));
    @(negedge clk);
    input_tile = t; kernel = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_at = -1; ce_cnt = 0; ce_bad = 0; lane_bad = 0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      if (disturb) begin
        if (n == 5)  start = 1'b1;
        if (n == 6)  start = 1'b0;
        if (n == 10) input_tile = ~t;
        if (n == 33) start = 1'b1;
        if (n == 34) start = 1'b0;
      end
      if (n == 2 && has_prev) chk("c33_held_from_prev", 32'(c[3][3]), 32'(last_c33));
      if (dsp_ce) begin
        ce_cnt++;
        if (n < 1 || n > 32) ce_bad++;
      end
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (n >= 1 && n <= 32) begin
        p = (n - 1) / 2; ph = (n - 1) % 2; i = p / 4; j = p % 4;
        for (int l = 0; l < 5; l++) begin
          tap = ph ? l + 5 : l;
          if (tap > 8) begin
            ea = '0; eb = '0;
          end else begin
            ea = {10'd0, t[i + tap/3][j + tap%3]};
            eb = {10'd0, k[tap/3][tap%3]};
          end
          if (dsp_a0[l] !== ea || dsp_b0[l] !== eb) lane_bad++;
        end
      end else if (dsp_a0 != '0 || dsp_b0 != '0) lane_bad++;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_at), 32'd33);
    chk("dsp_ce_cycles", 32'(ce_cnt), 32'd32);
    chk("dsp_ce_outside_job", 32'(ce_bad), 32'd0);
    chk("lane_operand_errs", 32'(lane_bad), 32'd0);
    chk("c00_table", 32'(c[0][0]), 32'(c00_exp));
    chk("c33_table", 32'(c[3][3]), 32'(c33_exp));
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("c[%0d][%0d]", r, q), 32'(c[r][q]), 32'(got));
        end
      end
    last_c33 = c33_exp;
    has_prev = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) chk($sformatf("%s_c[%0d][%0d]", tag, r, q), 32'(c[r][q]), 32'd0);
    chk({tag, "_dsp_ce"}, 32'(dsp_ce), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dsp_ops"}, 32'(dsp_a0 != '0 || dsp_b0 != '0), 32'd0);
  endtask

  task automatic abort_job(input tile_t t, input kern_t k);
    int done_cnt;
    @(negedge clk);
    input_tile = t; kernel = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_ce_before_reset", 32'(dsp_ce), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || dsp_ce) done_cnt++;
    end
    chk("abort_no_activity", 32'(done_cnt), 32'd0);
    last_c33 = 16'd0;
  endtask

  initial begin
    tile_t t;
    kern_t k;
    errors = 0; checks = 0; has_prev = 1'b0;
    rst_n = 1'b0; start = 1'b0; input_tile = '0; kernel = '0;

    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++) vecs[0].tile[r][q] = 8'h01;
    vecs[0].kern = {9{8'h01}}; vecs[0].c00 = 16'h0009; vecs[0].c33 = 16'h0009;
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++) vecs[1].tile[r][q] = 8'(r * 6 + q);
    vecs[1].kern = '0; vecs[1].kern[1][1] = 8'h01;
    vecs[1].c00 = 16'h0007; vecs[1].c33 = 16'h001C;
    vecs[2].tile = {36{8'hFF}}; vecs[2].kern = {9{8'hFF}};
    vecs[2].c00 = 16'hEE09; vecs[2].c33 = 16'hEE09;
    for (int v = 3; v < 5; v++) begin
      for (int r = 0; r < 6; r++)
        for (int q = 0; q < 6; q++) vecs[v].tile[r][q] = 8'($urandom_range(0, 255));
      for (int r = 0; r < 3; r++)
        for (int q = 0; q < 3; q++) vecs[v].kern[r][q] = 8'($urandom_range(0, 255));
      vecs[v].c00 = conv(vecs[v].tile, vecs[v].kern, 0, 0);
      vecs[v].c33 = conv(vecs[v].tile, vecs[v].kern, 3, 3);
    end

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_job(vecs[v].tile, vecs[v].kern, 1'b0, vecs[v].c00, vecs[v].c33);

    // Re-pulse start and corrupt the tile mid-job; results must follow the snapshot.
    run_job(vecs[1].tile, vecs[1].kern, 1'b1, vecs[1].c00, vecs[1].c33);

    abort_job(vecs[2].tile, vecs[2].kern);
    run_job(vecs[3].tile, vecs[3].kern, 1'b0, vecs[3].c00, vecs[3].c33);

    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++) t[r][q] = 8'($urandom_range(200, 255));
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) k[r][q] = 8'($urandom_range(0, 255));
    run_job(t, k, 1'b1, conv(t, k, 0, 0), conv(t, k, 3, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
